// File: rtl/bus_write_monitor.sv
// bus_write_monitor
//   Passive snoop on the CPU memory bus. Every CPU write is logged into a
//   show-ahead FIFO and folded into a 16-bit signature. The last byte
//   written to WATCH_ADDR is latched. A jump-to-self loop (HALT_REPEAT
//   consecutive opcode fetches from one address) raises a sticky halt flag.
//
//   Optional build macro: MONITOR_FETCH_LOG_EN
//     When defined, opcode fetches are also logged (kind = 1, data = 8'h00).
//     A fetch that coincides with a write is parked in a one-entry skid
//     register and enqueued on a later edge.
//     When undefined, only writes are logged and log_kind is tied to 0.
//
//   Ports
//     ph2        : clock, all state changes on its rising edge
//     resetb     : synchronous active-low reset
//     bus_addr   : CPU address (qualified by bus_we / bus_fetch)
//     bus_wdata  : CPU write data
//     bus_we     : one-cycle write strobe
//     bus_fetch  : one-cycle opcode fetch strobe (SYNC)
//     log_rd     : pop the head entry (ignored while empty)
//     log_valid  : FIFO holds at least one entry
//     log_addr   : head entry address
//     log_data   : head entry data
//     log_kind   : head entry type, 0 = write, 1 = fetch
//     log_count  : number of entries held
//     overflow   : sticky, an entry was dropped
//     signature  : running write signature
//     watch_hit  : sticky, WATCH_ADDR has been written
//     watch_data : last byte written to WATCH_ADDR
//     halted     : sticky halt flag
module bus_write_monitor #(
  parameter int          DEPTH       = 16,
  parameter logic [15:0] WATCH_ADDR  = 16'h0030,
  parameter int          HALT_REPEAT = 3
) (
  input  logic                   ph2,
  input  logic                   resetb,
  input  logic [15:0]            bus_addr,
  input  logic [7:0]             bus_wdata,
  input  logic                   bus_we,
  input  logic                   bus_fetch,
  input  logic                   log_rd,
  output logic                   log_valid,
  output logic [15:0]            log_addr,
  output logic [7:0]             log_data,
  output logic                   log_kind,
  output logic [$clog2(DEPTH):0] log_count,
  output logic                   overflow,
  output logic [15:0]            signature,
  output logic                   watch_hit,
  output logic [7:0]             watch_data,
  output logic                   halted
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = $clog2(HALT_REPEAT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [RW-1:0] REP_MAX  = RW'(HALT_REPEAT);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  // Signature step: 16-bit LFSR shift with the bus byte pair XORed in.
  function automatic logic [15:0] sig_next(input logic [15:0] s,
                                           input logic [7:0]  a,
                                           input logic [7:0]  d);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb} ^ {a, d};
  endfunction

  // FIFO storage (data only, never reset) and control
  logic [23:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic          push_vld;
  logic [15:0]   push_addr;
  logic [7:0]    push_data;
  logic          fetch_drop;
  logic          pop, full, accept;

  logic [15:0]   sig_q, sig_d;
  logic          hit_q, hit_d;
  logic [7:0]    wdata_q, wdata_d;

  logic [0:0]    state_q, state_d;
  logic [RW-1:0] rep_q, rep_d;
  logic [15:0]   last_q, last_d;

`ifdef MONITOR_FETCH_LOG_EN
  logic          kind_mem_q [DEPTH];
  logic          push_kind;
  logic          skid_vld_q, skid_vld_d;
  logic [15:0]   skid_addr_q, skid_addr_d;

  // Push source priority: current write, then parked fetch, then new fetch.
  // A fetch that cannot be parked (skid already occupied) is dropped.
  always_comb begin
    push_vld    = 1'b0;
    push_addr   = '0;
    push_data   = '0;
    push_kind   = 1'b0;
    fetch_drop  = 1'b0;
    skid_vld_d  = skid_vld_q;
    skid_addr_d = skid_addr_q;
    if (bus_we) begin
      push_vld  = 1'b1;
      push_addr = bus_addr;
      push_data = bus_wdata;
      if (bus_fetch) begin
        if (!skid_vld_q) begin
          skid_vld_d  = 1'b1;
          skid_addr_d = bus_addr;
        end else begin
          fetch_drop = 1'b1;
        end
      end
    end else if (skid_vld_q) begin
      push_vld  = 1'b1;
      push_addr = skid_addr_q;
      push_kind = 1'b1;
      if (bus_fetch) begin
        skid_addr_d = bus_addr;
      end else begin
        skid_vld_d = 1'b0;
      end
    end else if (bus_fetch) begin
      push_vld  = 1'b1;
      push_addr = bus_addr;
      push_kind = 1'b1;
    end
  end
`else
  always_comb begin
    push_vld   = bus_we;
    push_addr  = bus_addr;
    push_data  = bus_wdata;
    fetch_drop = 1'b0;
  end
`endif

  // FIFO bookkeeping; a pop frees the slot for a push on a full FIFO
  always_comb begin
    pop        = log_rd && (count_q != '0);
    full       = (count_q == FULL_CNT);
    accept     = push_vld && (!full || pop);
    wr_ptr_d   = accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q;
    if (accept && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!accept && pop) begin
      count_d = count_q - CW'(1);
    end
    overflow_d = overflow_q | (push_vld && !accept) | fetch_drop;
  end

  // Signature and watch register, updated by every write regardless of FIFO
  always_comb begin
    sig_d   = sig_q;
    hit_d   = hit_q;
    wdata_d = wdata_q;
    if (bus_we) begin
      sig_d = sig_next(sig_q, bus_addr[7:0], bus_wdata);
      if (bus_addr == WATCH_ADDR) begin
        hit_d   = 1'b1;
        wdata_d = bus_wdata;
      end
    end
  end

  // Halt detection: rep counts consecutive fetches from last_q.
  // After reset rep is 0, so even a first fetch from 16'h0000 yields rep = 1.
  always_comb begin
    rep_d   = rep_q;
    last_d  = last_q;
    state_d = state_q;
    if (bus_fetch) begin
      if (bus_addr == last_q) begin
        if (rep_q != REP_MAX) begin
          rep_d = rep_q + RW'(1);
        end
      end else begin
        rep_d  = RW'(1);
        last_d = bus_addr;
      end
      if ((state_q == ST_RUN) && (rep_d == REP_MAX)) begin
        state_d = ST_HALTED;
      end
    end
  end

  always_ff @(posedge ph2) begin
    if (!resetb) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      sig_q      <= 16'h0000;
      hit_q      <= 1'b0;
      wdata_q    <= 8'h00;
      state_q    <= ST_RUN;
      rep_q      <= '0;
      last_q     <= 16'h0000;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      sig_q      <= sig_d;
      hit_q      <= hit_d;
      wdata_q    <= wdata_d;
      state_q    <= state_d;
      rep_q      <= rep_d;
      last_q     <= last_d;
    end
  end

`ifdef MONITOR_FETCH_LOG_EN
  always_ff @(posedge ph2) begin
    if (!resetb) begin
      skid_vld_q  <= 1'b0;
      skid_addr_q <= 16'h0000;
    end else begin
      skid_vld_q  <= skid_vld_d;
      skid_addr_q <= skid_addr_d;
    end
  end

  always_ff @(posedge ph2) begin
    if (accept) begin
      kind_mem_q[wr_ptr_q] <= push_kind;
    end
  end

  assign log_kind = log_valid & kind_mem_q[rd_ptr_q];
`else
  assign log_kind = 1'b0;
`endif

  always_ff @(posedge ph2) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= {push_addr, push_data};
    end
  end

  // Head fields read as zero while empty, which also gives zero after reset
  assign log_valid  = (count_q != '0);
  assign log_addr   = log_valid ? mem_q[rd_ptr_q][23:8] : 16'h0000;
  assign log_data   = log_valid ? mem_q[rd_ptr_q][7:0]  : 8'h00;
  assign log_count  = count_q;
  assign overflow   = overflow_q;
  assign signature  = sig_q;
  assign watch_hit  = hit_q;
  assign watch_data = wdata_q;
  assign halted     = (state_q == ST_HALTED);

endmodule

// File: tb/tb_bus_write_monitor.sv
module tb_bus_write_monitor;

  localparam int          DEPTH       = 16;
  localparam logic [15:0] WATCH_ADDR  = 16'h0030;
  localparam int          HALT_REPEAT = 3;

  logic                   ph2 = 1'b0;
  logic                   resetb;
  logic [15:0]            bus_addr;
  logic [7:0]             bus_wdata;
  logic                   bus_we;
  logic                   bus_fetch;
  logic                   log_rd;
  logic                   log_valid;
  logic [15:0]            log_addr;
  logic [7:0]             log_data;
  logic                   log_kind;
  logic [$clog2(DEPTH):0] log_count;
  logic                   overflow;
  logic [15:0]            signature;
  logic                   watch_hit;
  logic [7:0]             watch_data;
  logic                   halted;

  bus_write_monitor #(
    .DEPTH(DEPTH), .WATCH_ADDR(WATCH_ADDR), .HALT_REPEAT(HALT_REPEAT)
  ) dut (
    .ph2(ph2), .resetb(resetb), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_we(bus_we), .bus_fetch(bus_fetch), .log_rd(log_rd),
    .log_valid(log_valid), .log_addr(log_addr), .log_data(log_data),
    .log_kind(log_kind), .log_count(log_count), .overflow(overflow),
    .signature(signature), .watch_hit(watch_hit), .watch_data(watch_data),
    .halted(halted)
  );

  always #5 ph2 = ~ph2;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
    logic        k;
  } ent_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  // Scoreboard: entries the FIFO should hand out, oldest first
  ent_t exp_q[$];

  // Reference model state
  int          m_cnt;
  bit          m_ovf;
  logic [15:0] m_sig;
  bit          m_hit;
  logic [7:0]  m_wd;
  bit          m_halt;
  bit          m_first;
  logic [15:0] m_last;
  int          m_run;
  bit          m_clean;
`ifdef MONITOR_FETCH_LOG_EN
  logic [15:0] m_pend[$];
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_cnt = 0; m_ovf = 0; m_sig = 16'h0000; m_hit = 0; m_wd = 8'h00;
    m_halt = 0; m_first = 1; m_last = 16'h0000; m_run = 0; m_clean = 1;
    exp_q.delete();
`ifdef MONITOR_FETCH_LOG_EN
    m_pend.delete();
`endif
  endtask

  task automatic m_push(input ent_t e);
    if (m_cnt < DEPTH) begin
      exp_q.push_back(e);
      m_cnt++;
      m_clean = 0;
    end else begin
      m_ovf = 1;
    end
  endtask

  // Effect of one clock edge on the reference model
  task automatic m_edge(input bit rst_n, input bit we, input bit fe,
                        input logic [15:0] a, input logic [7:0] d, input bit rd);
    logic fb;
    if (!rst_n) begin
      m_reset();
      return;
    end
    if (rd && m_cnt > 0) m_cnt--;
`ifdef MONITOR_FETCH_LOG_EN
    // One FIFO push per edge; writes go first, fetches wait in a 1-deep list
    if (we) begin
      m_push('{a: a, d: d, k: 1'b0});
      if (fe) begin
        if (m_pend.size() == 0) m_pend.push_back(a);
        else m_ovf = 1;
      end
    end else begin
      if (fe) m_pend.push_back(a);
      if (m_pend.size() != 0) m_push('{a: m_pend.pop_front(), d: 8'h00, k: 1'b1});
    end
`else
    if (we) m_push('{a: a, d: d, k: 1'b0});
`endif
    if (we) begin
      fb    = m_sig[15] ^ m_sig[13] ^ m_sig[12] ^ m_sig[10];
      m_sig = {m_sig[14:0], fb} ^ {a[7:0], d};
      if (a == WATCH_ADDR) begin
        m_hit = 1;
        m_wd  = d;
      end
    end
    if (fe) begin
      if (!m_first && a == m_last) m_run++;
      else begin
        m_run  = 1;
        m_last = a;
      end
      m_first = 0;
      if (m_run >= HALT_REPEAT) m_halt = 1;
    end
  endtask

  // Drive one cycle: inputs applied after the previous edge, model advanced
  // at the edge, caller resumes 1 time unit after the edge
  task automatic step(input bit rst_n, input bit we, input bit fe,
                      input logic [15:0] a, input logic [7:0] d, input bit rd);
    resetb    = rst_n;
    bus_we    = we;
    bus_fetch = fe;
    bus_addr  = a;
    bus_wdata = d;
    log_rd    = rd;
    @(posedge ph2);
    m_edge(rst_n, we, fe, a, d, rd);
    #1;
  endtask

  task automatic idle(input bit rd);
    step(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, rd);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d, input bit rd);
    step(1'b1, 1'b1, 1'b0, a, d, rd);
  endtask

  task automatic fetch(input logic [15:0] a);
    step(1'b1, 1'b0, 1'b1, a, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
  endtask

  // Monitor: compares DUT status and head entry against model/scoreboard
  always @(negedge ph2) begin
    if (mon_en) begin
      check("log_count", 32'(log_count), 32'(m_cnt));
      check("log_valid", 32'(log_valid), 32'(m_cnt != 0));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("signature", 32'(signature), 32'(m_sig));
      check("watch_hit", 32'(watch_hit), 32'(m_hit));
      check("watch_data", 32'(watch_data), 32'(m_wd));
      check("halted", 32'(halted), 32'(m_halt));
      if (log_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL head: DUT shows %h/%h/%b, scoreboard empty", log_addr, log_data, log_kind);
        end else begin
          check("head", 32'({log_addr, log_data, log_kind}), 32'(exp_q[0]));
          if (log_rd) void'(exp_q.pop_front());
        end
      end else if (m_clean) begin
        check("head_after_reset", 32'({log_addr, log_data, log_kind}), 32'h0);
      end
    end
  end

  initial begin
    logic [15:0] last_a;
    resetb = 1'b0; bus_we = 1'b0; bus_fetch = 1'b0; log_rd = 1'b0;
    bus_addr = '0; bus_wdata = '0;
    m_reset();
    do_reset();
    do_reset();
    mon_en = 1'b1;

    // Reset values
    check("rst_count", 32'(log_count), 0);
    check("rst_valid", 32'(log_valid), 0);
    check("rst_sig", 32'(signature), 0);
    check("rst_halted", 32'(halted), 0);

    // Single write to the watched address
    wr(16'h0030, 8'hCE, 1'b0);
    check("w1_valid", 32'(log_valid), 1);
    check("w1_addr", 32'(log_addr), 32'h0030);
    check("w1_data", 32'(log_data), 32'hCE);
    check("w1_sig", 32'(signature), 32'h30CE);
    check("w1_hit", 32'(watch_hit), 1);
    check("w1_wd", 32'(watch_data), 32'hCE);

    // Jump-to-self detection
    do_reset();
    fetch(16'hF000);
    fetch(16'hF001);
    fetch(16'hF005);
    fetch(16'hF005);
    check("halt_pre", 32'(halted), 0);
    fetch(16'hF005);
    check("halt_rise", 32'(halted), 1);
    fetch(16'hF006);
    check("halt_sticky", 32'(halted), 1);

    // Overflow: DEPTH+2 writes without reads, then drain
    do_reset();
    for (int i = 0; i < DEPTH + 2; i++) wr(16'h0100 + 16'(i), 8'(i + 1), 1'b0);
    check("ovf_count", 32'(log_count), DEPTH);
    check("ovf_flag", 32'(overflow), 1);
    for (int i = 0; i < DEPTH; i++) idle(1'b1);
    idle(1'b1);
    check("drain_count", 32'(log_count), 0);
    check("empty_rd_valid", 32'(log_valid), 0);

    // Full FIFO with simultaneous write and pop
    do_reset();
    for (int i = 0; i < DEPTH; i++) wr(16'h0200 + 16'(i), 8'(i + 8'h40), 1'b0);
    wr(16'h02FF, 8'hEE, 1'b1);
    check("fullrw_count", 32'(log_count), DEPTH);
    check("fullrw_ovf", 32'(overflow), 0);
    for (int i = 0; i < DEPTH - 1; i++) idle(1'b1);
    check("fullrw_tail_addr", 32'(log_addr), 32'h02FF);
    check("fullrw_tail_data", 32'(log_data), 32'hEE);
    idle(1'b1);

    // Last write to the watch address wins; mid-stream reset clears all
    do_reset();
    wr(16'h0030, 8'h11, 1'b0);
    wr(16'h0030, 8'h22, 1'b0);
    check("watch_last", 32'(watch_data), 32'h22);
    fetch(16'h0400); fetch(16'h0400); fetch(16'h0400);
    check("pre_rst_halted", 32'(halted), 1);
    do_reset();
    check("mid_rst_count", 32'(log_count), 0);
    check("mid_rst_valid", 32'(log_valid), 0);
    check("mid_rst_sig", 32'(signature), 0);
    check("mid_rst_hit", 32'(watch_hit), 0);
    check("mid_rst_wd", 32'(watch_data), 0);
    check("mid_rst_halted", 32'(halted), 0);
    check("mid_rst_addr", 32'(log_addr), 0);

    // Fetch followed by a write
    fetch(16'hF000);
    wr(16'h0200, 8'h5A, 1'b0);
    check("fw_sig", 32'(signature), 32'h005A);
`ifdef MONITOR_FETCH_LOG_EN
    check("fw_count", 32'(log_count), 2);
    check("fw_head", 32'({log_addr, log_data, log_kind}), 32'({16'hF000, 8'h00, 1'b1}));
`else
    check("fw_count", 32'(log_count), 1);
    check("fw_head", 32'({log_addr, log_data, log_kind}), 32'({16'h0200, 8'h5A, 1'b0}));
`endif
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Randomized traffic against the model
    do_reset();
    last_a = 16'hF000;
    for (int i = 0; i < 3000; i++) begin
      bit rs, we, fe, rd;
      logic [15:0] a;
      logic [7:0]  d;
      rs = ($urandom_range(0, 399) == 0);
      we = ($urandom_range(0, 99) < 40);
      fe = ($urandom_range(0, 99) < 30);
      rd = ($urandom_range(0, 99) < (((i % 600) < 300) ? 15 : 65));
      case ($urandom_range(0, 3))
        0:       a = WATCH_ADDR;
        1:       a = last_a;
        2:       a = 16'hF000 + 16'($urandom_range(0, 1));
        default: a = 16'($urandom);
      endcase
      d = 8'($urandom);
      last_a = a;
      step(!rs, we, fe, a, d, rd);
    end
    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
    check("final_count", 32'(log_count), 0);

    @(negedge ph2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_write_monitor.md
Name: bus_write_monitor

Overview:
- Passive snoop on the CPU memory bus, sitting directly downstream of the core alongside `top.mem`.
- Records every CPU write into a small log FIFO and folds each write into a 16-bit signature.
- Latches the last byte written to a watched result address.
- Detects the jump-to-self end-of-test loop, so benches read one `halted`/`watch_data` pair instead of probing RAM after a fixed delay.

Parameters:
- DEPTH, 16, log FIFO entries (power of 2, 2..64).
- WATCH_ADDR, 16'h0030, result address whose writes are latched into `watch_data`.
- HALT_REPEAT, 3, consecutive opcode fetches from an identical address that declare halt (>=2).

Ports:
- ph2  input  1  sole clock; all state updates on its rising edge.
- resetb  input  1  synchronous, active-low reset.
- bus_addr  input  16  CPU address, valid when `bus_we` or `bus_fetch` is high.
- bus_wdata  input  8  CPU write data.
- bus_we  input  1  one-cycle write strobe.
- bus_fetch  input  1  one-cycle opcode-fetch strobe (SYNC).
- log_rd  input  1  pop head entry.
- log_valid  output  1  FIFO non-empty.
- log_addr  output  16  head entry address (show-ahead).
- log_data  output  8  head entry data.
- log_kind  output  1  head entry type: 0 = write, 1 = fetch.
- log_count  output  $clog2(DEPTH)+1  entries held.
- overflow  output  1  sticky: an entry was dropped.
- signature  output  16  running write signature.
- watch_hit  output  1  sticky: `WATCH_ADDR` has been written.
- watch_data  output  8  last byte written to `WATCH_ADDR`.
- halted  output  1  sticky halt flag.

Behaviour:
- Reset (`resetb` = 0 at a `ph2` edge): FIFO empty, `log_count` = 0, `log_valid` = 0.
  - `log_addr`/`log_data`/`log_kind` = 0; `overflow` = 0; `signature` = 16'h0000.
  - `watch_hit` = 0, `watch_data` = 8'h00, `halted` = 0.
  - Fetch-repeat counter = 0; last-fetch register = 16'h0000.
  - Reset asserted mid-operation discards all contents on that edge.
- Write capture: on an edge with `bus_we` = 1, enqueue {`bus_addr`, `bus_wdata`, kind 0}. Visible at the head one cycle later when the FIFO was empty.
- Signature, per accepted `bus_we`, independent of FIFO state:
  - fb = sig[15]^sig[13]^sig[12]^sig[10]
  - sig <= {sig[14:0], fb} ^ {bus_addr[7:0], bus_wdata}
  - Continues to update after overflow and after halt.
- Watch: `bus_we` with `bus_addr` == `WATCH_ADDR` sets `watch_hit` and loads `watch_data` on the same edge. The last write wins.
- FIFO rules:
  - Outputs show the head entry; `log_valid` = (`log_count` != 0).
  - Pop when `log_rd` and `log_valid`. `log_rd` while empty is ignored.
  - Push while full and not popping: entry dropped, `overflow` set, count unchanged.
  - Push and pop on the same edge while full: both happen, count stays DEPTH, no overflow.
  - Push and pop on the same edge while empty: push only, count becomes 1.
  - Pointers wrap modulo DEPTH.
- Halt FSM states:
  - RUN: `halted` = 0.
  - On `bus_fetch`: if `bus_addr` == last-fetch, rep <= rep+1 (saturating at HALT_REPEAT); else rep <= 1 and last-fetch <= `bus_addr`.
  - RUN -> HALTED when the fetch makes rep reach HALT_REPEAT. `halted` rises on that edge.
  - HALTED: sticky until reset. Writes are still logged.
  - The first fetch after reset always starts with rep = 1.
- `bus_we` and `bus_fetch` on the same edge: only the write is logged; the fetch still drives the halt FSM.

Optional Feature:
- Macro: MONITOR_FETCH_LOG_EN.
- Defined: each `bus_fetch` also enqueues {`bus_addr`, 8'h00, kind 1}, with the same full/overflow rules. If `bus_we` and `bus_fetch` coincide, the write is enqueued first, then the fetch on the next edge via a one-entry skid register. The signature is unaffected by fetches.
- Undefined: fetches are never logged and `log_kind` is tied to 0.

Test Plan:
- Reset, then one write addr 16'h0030 data 8'hCE -> `log_valid` = 1, head {0030, CE}, `signature` = 16'h30CE, `watch_hit` = 1, `watch_data` = 8'hCE.
- Fetches at F000, F001, F005, F005, F005 -> `halted` rises on the third F005 edge; fetch at F006 afterward leaves `halted` = 1.
- DEPTH+2 writes, no reads -> `log_count` = DEPTH, `overflow` = 1; pops return the first DEPTH writes in order.
- Full FIFO with simultaneous write and `log_rd` -> count stays DEPTH, `overflow` stays 0, new entry lands at the tail.
- Writes 0030 = 11 then 0030 = 22 -> `watch_data` = 8'h22; `resetb` low for one edge mid-stream -> all outputs return to reset values.
- With MONITOR_FETCH_LOG_EN: fetch F000, then write 0200 = 5A -> head {F000, 00, kind 1}, then {0200, 5A, kind 0}; `signature` = 16'h005A.
